user_cell_tester: RTL

USER_CELL_TESTER -- requirements
Module: user_cell_tester

---
 rtl/user_cell_tester.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/user_cell_tester.sv
// user_cell_tester: Wishbone-programmable stimulus/response sequencer for a cell
// under test. It applies vectors on stim_o, waits a programmable settle time,
// then captures resp_i into LAST_RESP, a MISR signature and a mismatch counter.
// Optional feature: define CELLTEST_LFSR_EN to make the sweep advance a 32-bit
// Galois LFSR instead of a +1 increment.
module user_cell_tester #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned RESP_W    = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [31:0]       stim_o,
  input  logic [RESP_W-1:0] resp_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_NEXT    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [26:0] BASE_HI = BASE_ADDR[31:5];

  state_t            state_q, state_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [31:0]       pattern_q, pattern_d;
  logic [31:0]       expected_q, expected_d;
  logic [15:0]       count_q, count_d;
  logic              mode_q, mode_d;
  logic [7:0]        settle_q, settle_d;
  logic [7:0]        settle_cnt_q, settle_cnt_d;
  logic [15:0]       remain_q, remain_d;
  logic [15:0]       mismatch_q, mismatch_d;
  logic [RESP_W-1:0] last_resp_q, last_resp_d;
  logic [31:0]       sig_q, sig_d;
  logic [31:0]       stim_q, stim_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              hit, req, wr, busy_now, start_req, abort_req;
  logic [2:0]        offset;
  logic [31:0]       wmask;
  logic [31:0]       rd_data;
  logic [31:0]       stim_adv, stim_load;
  logic [31:0]       resp_ext, sig_shift;
  logic              unused_adr_lsbs;

  assign unused_adr_lsbs = ^wbs_adr_i[1:0];

  // Expand the byte selects into a bit mask used to merge partial writes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wmask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
    end
  endgenerate

  // Bus decode: a new access is accepted only when no ack is outstanding.
  always_comb begin
    busy_now  = (state_q == S_APPLY) || (state_q == S_SETTLE) ||
                (state_q == S_CAPTURE) || (state_q == S_NEXT);
    hit       = (wbs_adr_i[31:5] == BASE_HI);
    req       = wbs_stb_i && wbs_cyc_i && !ack_q && hit;
    wr        = req && wbs_we_i;
    offset    = wbs_adr_i[4:2];
    start_req = wr && (offset == 3'd0) && wbs_sel_i[0] && wbs_dat_i[0];
    abort_req = wr && (offset == 3'd0) && wbs_sel_i[0] && wbs_dat_i[1];
    resp_ext  = 32'(resp_i);
    sig_shift = {sig_q[30:0], sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0]};
  end

  // Stimulus load/advance rules: LFSR when enabled, otherwise a plain increment.
  always_comb begin
`ifdef CELLTEST_LFSR_EN
    stim_adv  = {1'b0, stim_q[31:1]} ^ (stim_q[0] ? 32'h8020_0003 : 32'h0);
    stim_load = (pattern_q == 32'h0) ? 32'h1 : pattern_q;
`else
    stim_adv  = stim_q + 32'd1;
    stim_load = pattern_q;
`endif
  end

  // Register read mux; START/ABORT are pulses and always read back as 0.
  always_comb begin
    case (offset)
      3'd0:    rd_data = {16'h0, settle_q, 5'h0, mode_q, 2'b00};
      3'd1:    rd_data = pattern_q;
      3'd2:    rd_data = expected_q;
      3'd3:    rd_data = {16'h0, count_q};
      3'd4:    rd_data = {mismatch_q, 14'h0, done_q, busy_q};
      3'd5:    rd_data = 32'(last_resp_q);
      3'd6:    rd_data = sig_q;
      default: rd_data = 32'h0;
    endcase
  end

  // Next-state logic: bus writes, then the sequencer (ABORT has priority).
  always_comb begin
    state_d      = state_q;
    ack_d        = req;
    dat_d        = dat_q;
    pattern_d    = pattern_q;
    expected_d   = expected_q;
    count_d      = count_q;
    mode_d       = mode_q;
    settle_d     = settle_q;
    settle_cnt_d = settle_cnt_q;
    remain_d     = remain_q;
    mismatch_d   = mismatch_q;
    last_resp_d  = last_resp_q;
    sig_d        = sig_q;
    stim_d       = stim_q;
    done_d       = done_q;

    if (req && !wbs_we_i) begin
      dat_d = rd_data;
    end

    // Configuration is frozen while a sequence is running.
    if (wr && !busy_now) begin
      case (offset)
        3'd0: begin
          if (wbs_sel_i[0]) mode_d   = wbs_dat_i[2];
          if (wbs_sel_i[1]) settle_d = wbs_dat_i[15:8];
        end
        3'd1: pattern_d  = (pattern_q & ~wmask) | (wbs_dat_i & wmask);
        3'd2: expected_d = (expected_q & ~wmask) | (wbs_dat_i & wmask);
        3'd3: count_d    = (count_q & ~wmask[15:0]) | (wbs_dat_i[15:0] & wmask[15:0]);
        default: ;
      endcase
    end

    if (abort_req) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_req) begin
            stim_d     = stim_load;
            mismatch_d = 16'h0;
            sig_d      = 32'hFFFF_FFFF;
            done_d     = 1'b0;
            remain_d   = count_q;
            state_d    = S_APPLY;
          end
        end
        S_APPLY: begin
          settle_cnt_d = settle_q;
          state_d      = (settle_q == 8'd0) ? S_CAPTURE : S_SETTLE;
        end
        S_SETTLE: begin
          settle_cnt_d = settle_cnt_q - 8'd1;
          if (settle_cnt_q <= 8'd1) state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          last_resp_d = resp_i;
          sig_d       = sig_shift ^ resp_ext;
          if ((resp_i != expected_q[RESP_W-1:0]) && (mismatch_q != 16'hFFFF)) begin
            mismatch_d = mismatch_q + 16'd1;
          end
          state_d = S_NEXT;
        end
        S_NEXT: begin
          // A remaining count of 0 or 1 means this was the last vector.
          if (mode_q && (remain_q > 16'd1)) begin
            remain_d = remain_q - 16'd1;
            stim_d   = stim_adv;
            state_d  = S_APPLY;
          end else begin
            remain_d = 16'h0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_APPLY) || (state_d == S_SETTLE) ||
             (state_d == S_CAPTURE) || (state_d == S_NEXT);
  end

  // State and register update with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      ack_q        <= 1'b0;
      dat_q        <= 32'h0;
      pattern_q    <= 32'h0;
      expected_q   <= 32'h0;
      count_q      <= 16'h0;
      mode_q       <= 1'b0;
      settle_q     <= 8'h0;
      settle_cnt_q <= 8'h0;
      remain_q     <= 16'h0;
      mismatch_q   <= 16'h0;
      last_resp_q  <= '0;
      sig_q        <= 32'hFFFF_FFFF;
      stim_q       <= 32'h0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      dat_q        <= dat_d;
      pattern_q    <= pattern_d;
      expected_q   <= expected_d;
      count_q      <= count_d;
      mode_q       <= mode_d;
      settle_q     <= settle_d;
      settle_cnt_q <= settle_cnt_d;
      remain_q     <= remain_d;
      mismatch_q   <= mismatch_d;
      last_resp_q  <= last_resp_d;
      sig_q        <= sig_d;
      stim_q       <= stim_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign stim_o    = stim_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule
